// File: rtl/dcf77_load_sequencer_pkg.sv
// dcf77_load_sequencer_pkg: shared states, digit indices, periods and BCD limits for the DCF77 load sequencer.
package dcf77_load_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, LOAD, RUN} state_t;
  localparam logic [2:0] DIG_SU = 3'd0;
  localparam logic [2:0] DIG_ST = 3'd1;
  localparam logic [2:0] DIG_MU = 3'd2;
  localparam logic [2:0] DIG_MT = 3'd3;
  localparam logic [2:0] DIG_HU = 3'd4;
  localparam logic [2:0] DIG_HT = 3'd5;
  localparam logic [5:0][3:0] DIG_PERIOD = {4'd3, 4'd10, 4'd6, 4'd10, 4'd6, 4'd10};
  localparam logic [3:0] HU_WRAP_PERIOD = 4'd4;
  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] MIN_T_MAX = 3'd5;
  localparam logic [1:0] HR_T_MAX = 2'd2;
  localparam logic [3:0] HR_U_MAX_AT_20 = 4'd3;
endpackage

// File: rtl/dcf77_load_sequencer_frame_check.sv
// dcf77_frame_check: combinational range and parity validation of a captured DCF77 frame.
module dcf77_frame_check
  import dcf77_load_sequencer_pkg::*;
(
  input  logic [3:0] min_u,
  input  logic [2:0] min_t,
  input  logic [3:0] hr_u,
  input  logic [1:0] hr_t,
  input  logic       par_min,
  input  logic       par_hr,
  output logic       frame_ok
);
  assign frame_ok = min_u <= UNITS_MAX && min_t <= MIN_T_MAX && hr_u <= UNITS_MAX && hr_t <= HR_T_MAX
                    && !(hr_t == HR_T_MAX && hr_u > HR_U_MAX_AT_20) && par_min && par_hr;
endmodule

// File: rtl/dcf77_load_sequencer.sv
// dcf77_load_sequencer: validates a decoded DCF77 frame and presets the clock digit counters one digit at a time.
module dcf77_load_sequencer
  import dcf77_load_sequencer_pkg::*;
#(
  parameter int LOAD_HOLD = 1,
  parameter int ERR_W     = 4
) (
  input  logic             clk_control,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic [3:0]       min_u,
  input  logic [2:0]       min_t,
  input  logic [3:0]       hr_u,
  input  logic [1:0]       hr_t,
  input  logic             par_min,
  input  logic             par_hr,
  input  logic             tick_1hz,
  input  logic [1:0]       hr_t_live,
  output logic [5:0]       digit_reset,
  output logic [3:0]       cifra,
  output logic [3:0]       period_hu,
  output logic             tick_out,
  output logic             synced,
  output logic             busy,
  output logic             frame_drop,
  output logic [ERR_W-1:0] err_cnt
);
  state_t     state, state_next;
  logic [2:0] dig;
  logic [3:0] hold;
  logic [3:0] cap_min_u, cap_hr_u, digit_val;
  logic [2:0] cap_min_t;
  logic [1:0] cap_hr_t;
  logic       cap_par_min, cap_par_hr, frame_ok, last_step;

  dcf77_frame_check u_check (
    .min_u(cap_min_u), .min_t(cap_min_t), .hr_u(cap_hr_u), .hr_t(cap_hr_t),
    .par_min(cap_par_min), .par_hr(cap_par_hr), .frame_ok(frame_ok)
  );

  assign last_step = hold == 4'(LOAD_HOLD - 1);
  assign period_hu = hr_t_live == HR_T_MAX ? HU_WRAP_PERIOD : DIG_PERIOD[DIG_HU];

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RUN: state_next = frame_valid ? CHECK : state;
      CHECK:     state_next = frame_ok ? LOAD : (synced ? RUN : IDLE);
      LOAD:      state_next = last_step && dig == DIG_HT ? RUN : LOAD;
      default:   state_next = IDLE;
    endcase
    busy        = state == CHECK || state == LOAD;
    tick_out    = tick_1hz && !busy;
    frame_drop  = frame_valid && busy && !reset;
    digit_reset = state == LOAD ? 6'd1 << dig : 6'd0;
    digit_val   = dig == DIG_SU || dig == DIG_ST ? 4'd0 :
                  dig == DIG_MU ? cap_min_u :
                  dig == DIG_MT ? {1'b0, cap_min_t} :
                  dig == DIG_HU ? cap_hr_u : {2'b0, cap_hr_t};
    cifra       = state == LOAD ? digit_val + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk_control)
    if (reset) state <= IDLE;
    else state <= state_next;

  always_ff @(posedge clk_control) begin
    if (reset) begin
      {cap_min_u, cap_min_t, cap_hr_u, cap_hr_t, cap_par_min, cap_par_hr} <= '0;
      dig     <= DIG_SU;
      hold    <= '0;
      synced  <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (frame_valid && !busy)
        {cap_min_u, cap_min_t, cap_hr_u, cap_hr_t, cap_par_min, cap_par_hr} <=
          {min_u, min_t, hr_u, hr_t, par_min, par_hr};
      if (state == CHECK && !frame_ok && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (state == CHECK) begin
        dig  <= DIG_SU;
        hold <= '0;
      end else if (state == LOAD) begin
        hold <= last_step ? 4'd0 : hold + 4'd1;
        if (last_step) dig <= dig + 3'd1;
      end
      if (state == LOAD && state_next == RUN) synced <= 1'b1;
    end
  end
endmodule

// File: doc/dcf77_load_sequencer.md
DCF77_LOAD_SEQUENCER -- requirements
Module: dcf77_load_sequencer

Interface
REQ-001 Parameter LOAD_HOLD, default 1: clk_control cycles each digit_reset bit is held high; legal range 1..15.
REQ-002 Parameter ERR_W, default 4: width of the frame-error counter.
REQ-003 clk_control  in  1  system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 frame_valid  in  1  one-cycle pulse: a decoded DCF77 minute frame is present on the digit/parity inputs.
REQ-006 min_u  in  4  BCD minute units from the frame.
REQ-007 min_t  in  3  BCD minute tens.
REQ-008 hr_u  in  4  BCD hour units.
REQ-009 hr_t  in  2  BCD hour tens.
REQ-010 par_min, par_hr  in  1 each  parity-check-passed flags for the minute and hour fields.
REQ-011 tick_1hz  in  1  seconds tick toward the digit counter chain.
REQ-012 hr_t_live  in  2  current value of the hour-tens digit counter.
REQ-013 digit_reset  out  6  per-digit preset strobes: bit 0 sec units, 1 sec tens, 2 min units, 3 min tens, 4 hr units, 5 hr tens.
REQ-014 cifra  out  4  shared preset value for the digit whose strobe is active.
REQ-015 period_hu  out  4  period for the hour-units counter.
REQ-016 tick_out  out  1  gated seconds tick to the counter chain.
REQ-017 synced  out  1  at least one valid frame has been loaded since reset.
REQ-018 busy  out  1  high in CHECK and LOAD.
REQ-019 frame_drop  out  1  one-cycle pulse when a frame_valid is ignored.
REQ-020 err_cnt  out  ERR_W  saturating count of rejected frames.

Function
REQ-021 States: IDLE, CHECK, LOAD, RUN. Reset enters IDLE.
REQ-022 frame_valid in IDLE or RUN (cycle N): capture all digit and parity inputs into internal registers; state is CHECK in cycle N+1.
REQ-023 CHECK validation: min_u<=9, min_t<=5, hr_u<=9, hr_t<=2, (hr_t==2 implies hr_u<=3), par_min==1, par_hr==1.
REQ-024 CHECK pass: state is LOAD in cycle N+2. CHECK fail: err_cnt +1, saturating at all-ones; next state is RUN if synced, else IDLE.
REQ-025 LOAD order: digit indices 0..5; digit_reset[k] high exactly in cycles N+2+k*LOAD_HOLD through N+1+(k+1)*LOAD_HOLD; at most one bit high at any time.
REQ-026 cifra while digit_reset[k] is high: target digit + 1, 4-bit result. Seconds target 0, so sec units and sec tens get 1; other digits use captured values; e.g. captured minute units 7 gives cifra 8.
REQ-027 cifra is 0 whenever digit_reset is all zeros.
REQ-028 After the last digit: state is RUN and synced=1 in cycle N+2+6*LOAD_HOLD.
REQ-029 period_hu, combinational: 4 when hr_t_live==2, else 10; valid in every state.
REQ-030 tick_out = tick_1hz in IDLE and RUN; forced 0 in CHECK and LOAD, so no ticks are lost or duplicated mid-load.
REQ-031 frame_valid in CHECK or LOAD: ignored, frame_drop pulses in the same cycle, and captured registers are unchanged.
REQ-032 frame_valid coincident with the exit from LOAD: ignored, frame_drop pulses.
REQ-033 synced, once set, clears only on reset.

Reset
REQ-034 Reset values: state IDLE, digit_reset 0, cifra 0, tick_out 0, synced 0, busy 0, frame_drop 0, err_cnt 0, captured registers 0.
REQ-035 Reset asserted mid-LOAD: all digit_reset bits drop in the next cycle and no further digits load.
REQ-036 reset has priority over frame_valid in the same cycle.

Structure
REQ-037 Shared package holds: state enum, digit index constants (DIG_SU..DIG_HT), per-digit periods (10,6,10,6,10,3), hour-units wrap period 4, and BCD limit constants.
REQ-038 One sub-module, dcf77_frame_check: combinational validation of the captured fields per REQ-023, output frame_ok.

Verification
REQ-039 LOAD_HOLD=1, frame 13:47 with good parity at cycle 10 -> digit_reset one-hot bits 0..5 in cycles 12..17; cifra 1,1,8,5,4,2; synced=1 at cycle 18.
REQ-040 Frame hr_t=2, hr_u=5 -> no digit_reset activity, err_cnt=1, state returns IDLE.
REQ-041 20 bad-parity frames with ERR_W=4 -> err_cnt saturates at 15.
REQ-042 Second frame_valid two cycles after the first -> frame_drop pulse; the first frame's load completes unchanged.
REQ-043 Reset asserted during digit 3 with LOAD_HOLD=3 -> digit_reset 0 the next cycle, synced 0, state IDLE.
REQ-044 hr_t_live stepped 1->2->0 -> period_hu 10,4,10; tick_1hz pulses during LOAD never appear on tick_out.
